// File: rtl/stream_mux_4_to_1.sv
// stream_mux_4_to_1
//
// Purpose:
//   Merges four valid/ready producer streams onto one registered output stream.
//   Each output beat carries a 2-bit source channel tag {o_Sel1, o_Sel0}, so a
//   downstream 1-to-4 demux can route the beat back out by channel.
//   The default build arbitrates round-robin. Defining the macro
//   STREAM_MUX_FIXED_PRIORITY_EN switches to fixed priority (ch0 highest) and
//   removes the last-grant pointer.
//
// Ports:
//   i_Clk               system clock, rising edge
//   i_Rst_L             asynchronous active-low reset
//   i_Data0..i_Data3    channel payloads (DATA_WIDTH)
//   i_Valid0..i_Valid3  channel beat valid
//   o_Ready0..o_Ready3  channel beat accepted this cycle (combinational, one-hot or zero)
//   o_Data              registered merged payload
//   o_Valid             registered; o_Data / o_Sel1 / o_Sel0 are meaningful
//   i_Ready             sink accepts the beat when o_Valid & i_Ready
//   o_Sel1, o_Sel0      registered source channel index (00 = ch0 ... 11 = ch3)
//
// The output register state is simply o_Valid: EMPTY (0) or FULL (1).

module stream_mux_4_to_1 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [DATA_WIDTH-1:0] i_Data0,
    input  logic [DATA_WIDTH-1:0] i_Data1,
    input  logic [DATA_WIDTH-1:0] i_Data2,
    input  logic [DATA_WIDTH-1:0] i_Data3,
    input  logic                  i_Valid0,
    input  logic                  i_Valid1,
    input  logic                  i_Valid2,
    input  logic                  i_Valid3,
    output logic                  o_Ready0,
    output logic                  o_Ready1,
    output logic                  o_Ready2,
    output logic                  o_Ready3,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_Sel1,
    output logic                  o_Sel0
);

    logic [3:0]            valid_vec;
    logic [3:0]            ready_vec;
    logic                  load;
    logic                  grant_any;
    logic [1:0]            grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;

    assign valid_vec = {i_Valid3, i_Valid2, i_Valid1, i_Valid0};

    // Output register is empty, or its beat is being drained this same edge.
    assign load = !o_Valid || i_Ready;

`ifdef STREAM_MUX_FIXED_PRIORITY_EN

    // Fixed priority: lowest-numbered valid channel wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (valid_vec[k]) begin
                grant_any = 1'b1;
                grant_idx = 2'(k);
            end
        end
    end

`else

    logic [1:0] last_grant;
    logic [1:0] probe_idx;

    // Round-robin: search from last_grant+1 with wrap-around. The fourth probe
    // (k=4) wraps back to last_grant itself, so a lone requester that was also
    // the previous winner is still served.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        probe_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            probe_idx = last_grant + 2'(k);
            if (!grant_any && valid_vec[probe_idx]) begin
                grant_any = 1'b1;
                grant_idx = probe_idx;
            end
        end
    end

    // Reset value 3 makes ch0 the first channel searched after reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            last_grant <= 2'd3;
        end else if (load && grant_any) begin
            last_grant <= grant_idx;
        end
    end

`endif

    always_comb begin
        grant_data = i_Data0;
        case (grant_idx)
            2'd0:    grant_data = i_Data0;
            2'd1:    grant_data = i_Data1;
            2'd2:    grant_data = i_Data2;
            default: grant_data = i_Data3;
        endcase
    end

    // Ready is gated with the reset input so no producer sees an accept while
    // reset is held (o_Valid is 0 then, which would otherwise make load true).
    always_comb begin
        ready_vec = 4'b0000;
        if (load && grant_any && i_Rst_L) begin
            ready_vec = 4'b0001 << grant_idx;
        end
    end

    assign o_Ready0 = ready_vec[0];
    assign o_Ready1 = ready_vec[1];
    assign o_Ready2 = ready_vec[2];
    assign o_Ready3 = ready_vec[3];

    // Without load every output register holds (backpressure stall).
    // With load but no grant only o_Valid drops; data and tag hold.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Valid <= 1'b0;
            o_Data  <= '0;
            o_Sel1  <= 1'b0;
            o_Sel0  <= 1'b0;
        end else if (load) begin
            if (grant_any) begin
                o_Valid          <= 1'b1;
                o_Data           <= grant_data;
                {o_Sel1, o_Sel0} <= grant_idx;
            end else begin
                o_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_4_to_1.sv
// tb_stream_mux_4_to_1
//
// Purpose:
//   Directed-vector bench for stream_mux_4_to_1 with hand-computed expected
//   values. Inputs change 1 ns after a rising edge; combinational readies are
//   sampled on the falling edge and registered outputs 1 ns after the next
//   rising edge.
//   The last scenario expects fixed-priority behaviour when
//   STREAM_MUX_FIXED_PRIORITY_EN is defined and round-robin otherwise.

module tb_stream_mux_4_to_1;

    localparam int DW = 8;

    logic          i_Clk;
    logic          i_Rst_L;
    logic [DW-1:0] i_Data0, i_Data1, i_Data2, i_Data3;
    logic          i_Valid0, i_Valid1, i_Valid2, i_Valid3;
    logic          o_Ready0, o_Ready1, o_Ready2, o_Ready3;
    logic [DW-1:0] o_Data;
    logic          o_Valid;
    logic          i_Ready;
    logic          o_Sel1, o_Sel0;

    int n_vec;
    int n_miss;

    stream_mux_4_to_1 #(.DATA_WIDTH(DW)) dut (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Data0  (i_Data0),
        .i_Data1  (i_Data1),
        .i_Data2  (i_Data2),
        .i_Data3  (i_Data3),
        .i_Valid0 (i_Valid0),
        .i_Valid1 (i_Valid1),
        .i_Valid2 (i_Valid2),
        .i_Valid3 (i_Valid3),
        .o_Ready0 (o_Ready0),
        .o_Ready1 (o_Ready1),
        .o_Ready2 (o_Ready2),
        .o_Ready3 (o_Ready3),
        .o_Data   (o_Data),
        .o_Valid  (o_Valid),
        .i_Ready  (i_Ready),
        .o_Sel1   (o_Sel1),
        .o_Sel0   (o_Sel0)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdy();
        return 32'({o_Ready3, o_Ready2, o_Ready1, o_Ready0});
    endfunction

    function automatic logic [31:0] sel();
        return 32'({o_Sel1, o_Sel0});
    endfunction

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v);
        {i_Valid3, i_Valid2, i_Valid1, i_Valid0} = v;
    endtask

    task automatic expect_beat(input string tag, input logic [DW-1:0] d, input logic [1:0] s);
        check_vec({tag, "_valid"}, 32'(o_Valid), 32'd1);
        check_vec({tag, "_data"},  32'(o_Data),  32'(d));
        check_vec({tag, "_sel"},   sel(),        32'(s));
    endtask

    task automatic do_reset();
        i_Rst_L = 1'b0;
        step();
        i_Rst_L = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_ch;
        n_vec  = 0;
        n_miss = 0;
        i_Rst_L = 1'b0;
        i_Ready = 1'b0;
        i_Data0 = '0; i_Data1 = '0; i_Data2 = '0; i_Data3 = '0;
        set_valid(4'b0100);
        i_Data2 = 8'hA5;

        // Reset state, readies held low even with a channel valid
        step();
        step();
        check_vec("rst_valid", 32'(o_Valid), 32'd0);
        check_vec("rst_data",  32'(o_Data),  32'd0);
        check_vec("rst_sel",   sel(),        32'd0);
        check_vec("rst_ready", rdy(),        32'd0);

        // 1: single channel after release
        i_Rst_L = 1'b1;
        i_Ready = 1'b1;
        @(negedge i_Clk);
        check_vec("t1_ready", rdy(), 32'h4);
        check_vec("t1_pre_valid", 32'(o_Valid), 32'd0);
        step();
        expect_beat("t1", 8'hA5, 2'd2);
        set_valid(4'b0000);

        // 2: all four valid, round-robin from ch0
        do_reset();
        i_Data0 = 8'h10; i_Data1 = 8'h11; i_Data2 = 8'h12; i_Data3 = 8'h13;
        set_valid(4'b1111);
        i_Ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_ch = 2'(k);
            @(negedge i_Clk);
            check_vec($sformatf("t2_ready%0d", k), rdy(), 32'(4'b0001 << exp_ch));
            step();
            expect_beat($sformatf("t2_beat%0d", k), 8'h10 + 8'(exp_ch), exp_ch);
        end

        // 3: backpressure holding 0x11 (last = 3, so ch1 wins here)
        set_valid(4'b0010);
        step();
        expect_beat("t3_load", 8'h11, 2'd1);
        i_Ready = 1'b0;
        set_valid(4'b0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clk);
            check_vec($sformatf("t3_stall_ready%0d", k), rdy(), 32'd0);
            step();
            expect_beat($sformatf("t3_stall%0d", k), 8'h11, 2'd1);
        end
        i_Ready = 1'b1;
        @(negedge i_Clk);
        check_vec("t3_release_ready", rdy(), 32'h4);
        step();
        expect_beat("t3_after", 8'h12, 2'd2);

        // 4: wrap from ch3 to ch0, then ch1
        i_Data3 = 8'h33;
        set_valid(4'b1000);
        step();
        expect_beat("t4_ch3", 8'h33, 2'd3);
        i_Data0 = 8'h40; i_Data1 = 8'h41;
        set_valid(4'b0011);
        @(negedge i_Clk);
        check_vec("t4_ready_ch0", rdy(), 32'h1);
        step();
        expect_beat("t4_ch0", 8'h40, 2'd0);
        set_valid(4'b0010);
        @(negedge i_Clk);
        check_vec("t4_ready_ch1", rdy(), 32'h2);
        step();
        expect_beat("t4_ch1", 8'h41, 2'd1);

        // 5: asynchronous reset during a stall
        i_Ready = 1'b0;
        set_valid(4'b0000);
        step();
        expect_beat("t5_stalled", 8'h41, 2'd1);
        #2;
        i_Rst_L = 1'b0;
        #1;
        check_vec("t5_async_valid", 32'(o_Valid), 32'd0);
        check_vec("t5_async_data",  32'(o_Data),  32'd0);
        i_Data0 = 8'h50; i_Data3 = 8'h53;
        set_valid(4'b1001);
        i_Ready = 1'b1;
        #1;
        check_vec("t5_rst_ready", rdy(), 32'd0);
        step();
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        check_vec("t5_no_beat", 32'(o_Valid), 32'd0);
        check_vec("t5_ready_ch0", rdy(), 32'h1);
        step();
        expect_beat("t5_first", 8'h50, 2'd0);

        // 6: ch0 and ch1 continuously valid
        set_valid(4'b0000);
        do_reset();
        i_Data0 = 8'h60; i_Data1 = 8'h61;
        set_valid(4'b0011);
        i_Ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
`ifdef STREAM_MUX_FIXED_PRIORITY_EN
            exp_ch = 2'd0;
`else
            exp_ch = 2'(k % 2);
`endif
            @(negedge i_Clk);
            check_vec($sformatf("t6_ready%0d", k), rdy(), 32'(4'b0001 << exp_ch));
            step();
            expect_beat($sformatf("t6_beat%0d", k), 8'h60 + 8'(exp_ch), exp_ch);
        end

        // Drain: no requests left, output goes empty
        set_valid(4'b0000);
        step();
        check_vec("drain_valid", 32'(o_Valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stream_mux_4_to_1.md
Name: stream_mux_4_to_1

Overview:
- Merges four independent valid/ready data streams onto one output stream using round-robin arbitration.
- Registers the output and tags each beat with a 2-bit source channel index (o_Sel1, o_Sel0), so a downstream 1-to-4 demux can route the beat back out by channel.
- Sits at the convergence point of per-channel producers feeding one shared sink, for example a UART TX or a shared FIFO.

Parameters:
- DATA_WIDTH, 8, width of each data bus in bits.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Data0..i_Data3  input  DATA_WIDTH each  channel payloads.
- i_Valid0..i_Valid3  input  1 each  channel beat valid.
- o_Ready0..o_Ready3  output  1 each  channel beat accepted this cycle; combinational.
- o_Data  output  DATA_WIDTH  registered merged payload.
- o_Valid  output  1  registered; o_Data, o_Sel1 and o_Sel0 are valid.
- i_Ready  input  1  sink accepts the beat when o_Valid & i_Ready.
- o_Sel1  output  1  registered channel index, MSB.
- o_Sel0  output  1  registered channel index, LSB (00 = ch0 ... 11 = ch3).

Behaviour:
- Reset (i_Rst_L low, asynchronous):
  - o_Valid=0, o_Data=0, o_Sel1=0, o_Sel0=0.
  - Last-grant pointer = 3, so ch0 has first priority after reset.
  - o_Ready0..3 = 0 while reset is asserted.
  - Reset mid-transfer discards the held beat; no beat is emitted after release until a new grant.
- Handshake rules:
  - A beat transfers on a rising edge when valid and ready are both high.
  - Producers hold data and valid stable until ready; valid must never depend on ready.
- Load condition:
  - load = !o_Valid | i_Ready, meaning the output register is empty or draining this cycle.
- Arbitration (combinational):
  - Among channels with i_ValidN=1, grant the first one found searching from (last+1) mod 4 upward with wrap-around.
  - Exactly one grant or none.
  - o_ReadyN = load & grantN; never more than one o_ReadyN high.
- On an edge with load and any grant:
  - o_Data <= granted data; {o_Sel1,o_Sel0} <= granted index; o_Valid <= 1; last <= granted index.
- On an edge with load and no grant:
  - o_Valid <= 0; o_Data, o_Sel and last hold.
- On an edge without load (o_Valid=1, i_Ready=0):
  - All registers hold; all o_ReadyN = 0 (backpressure).
- Latency: 1 cycle from input handshake to o_Valid.
- Throughput: 1 beat/cycle sustained when i_Ready stays high, because drain and load happen in the same cycle.
- Fairness: with all four channels continuously valid and i_Ready=1, grant order is 0,1,2,3,0,... Any continuously valid channel waits at most 3 beats.
- Wrap-around: when last=3, the search starts at ch0.
- Simultaneous events: a new request arriving in the same cycle as another channel's request is resolved by the pointer only; there is no request age tracking.
- State summary (derived from o_Valid):
  - EMPTY (o_Valid=0) -> FULL on any grant.
  - FULL -> FULL on i_Ready & grant.
  - FULL -> EMPTY on i_Ready & no grant.
  - FULL -> FULL (stall) on !i_Ready.

Optional Feature:
- Macro: STREAM_MUX_FIXED_PRIORITY_EN.
- Defined:
  - Round-robin is replaced by fixed priority, ch0 highest and ch3 lowest.
  - The last-grant pointer is not implemented.
  - A continuously valid ch0 starves the other channels, by design.
- Undefined (default): round-robin as specified above.
- Handshake, latency, reset and o_Sel encoding are identical in both builds.

Test Plan:
1. Reset release, only i_Valid2=1 with i_Data2=0xA5, i_Ready=1 -> o_Ready2 high that cycle; next cycle o_Valid=1, o_Data=0xA5, o_Sel1/0=1/0.
2. All four valid with data 0x10,0x11,0x12,0x13, held, i_Ready=1 for 8 cycles -> output sequence 0x10,0x11,0x12,0x13,0x10,... with Sel 00,01,10,11,00; one beat per cycle.
3. Backpressure: o_Valid=1 carrying 0x11, i_Ready=0 for 3 cycles with ch2 valid -> o_Data stays 0x11, o_Ready0..3 all 0; on i_Ready=1, o_Ready2 pulses and 0x12 appears next cycle.
4. Wrap: last grant ch3, then ch1 and ch0 valid -> ch0 granted first, then ch1.
5. Reset mid-stall: o_Valid=1, i_Ready=0, assert i_Rst_L=0 asynchronously -> o_Valid drops immediately without a clock edge; after release, first grant goes to ch0 when ch0 and ch3 are both valid.
6. STREAM_MUX_FIXED_PRIORITY_EN defined, ch0 and ch1 continuously valid, i_Ready=1 for 5 cycles -> all five beats from ch0, o_Ready1 never asserted.
